// File: rtl/bcd_digits_to_binary_pkg.sv
// bcd2bin_pkg: shared state encoding, digit limit and result-width sizing for bcd_digits_to_binary.
package bcd2bin_pkg;
  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_e;
  localparam int BCD_MAX = 9;
  // Smallest width w with 10^ndig - 1 < 2^w.
  function automatic int min_bin_w(input int ndig);
    longint m;
    m = 1;
    for (int i = 0; i < ndig; i++) m = m * 10;
    return $clog2(m);
  endfunction
endpackage

// File: rtl/bcd_digits_to_binary_if.sv
// bcd_digits_to_binary_if: digit input and binary result handshakes of the BCD-to-binary accumulator.
interface bcd_digits_to_binary_if #(parameter int BIN_W = 14);
  logic [3:0] digit_in;
  logic digit_valid;
  logic digit_last;
  logic digit_ready;
  logic [BIN_W-1:0] bin_out;
  logic bin_valid;
  logic bin_ready;
  logic err_digit;
  modport slave (input digit_in, digit_valid, digit_last, bin_ready,
                 output digit_ready, bin_out, bin_valid, err_digit);
  modport master (output digit_in, digit_valid, digit_last, bin_ready,
                  input digit_ready, bin_out, bin_valid, err_digit);
endinterface

// File: rtl/bcd_digits_to_binary_mul10_add.sv
// mul10_add: combinational acc*10 + d as shift-add, truncated to BIN_W.
module mul10_add #(parameter int BIN_W = 14) (
  input  logic [BIN_W-1:0] acc_i,
  input  logic [3:0]       d_i,
  output logic [BIN_W-1:0] sum_o
);
  assign sum_o = (acc_i << 3) + (acc_i << 1) + BIN_W'(d_i);
endmodule

// File: rtl/bcd_digits_to_binary.sv
// bcd_digits_to_binary: serial MSD-first BCD digit accumulator with valid/ready result port.
// Define BCD2BIN_ERR_EN to flag digits 10-15 (sticky err_digit, counted as 0).
module bcd_digits_to_binary
  import bcd2bin_pkg::*;
#(
  parameter int NDIG  = 4,
  parameter int BIN_W = 14
) (
  input logic clock,
  input logic reset_b,
  bcd_digits_to_binary_if.slave bus
);
  localparam int CNT_W = $clog2(NDIG + 1);
  if (BIN_W < min_bin_w(NDIG)) begin : g_width_check
    $error("BIN_W too small to hold NDIG decimal digits");
  end
  state_e state_q, state_d;
  logic [BIN_W-1:0] acc_q, acc_d, acc_next, bin_q, bin_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0] d;
  logic frame_end;
`ifdef BCD2BIN_ERR_EN
  logic err_q, err_d, bad;
  assign bad = bus.digit_in > 4'(BCD_MAX);
  assign d = bad ? 4'd0 : bus.digit_in;
  assign err_d = state_q == HOLD ? (bus.bin_ready ? 1'b0 : err_q)
                                 : (bus.digit_valid ? (err_q | bad) : err_q);
  always_ff @(posedge clock or negedge reset_b)
    if (!reset_b) err_q <= 1'b0;
    else err_q <= err_d;
  assign bus.err_digit = err_q;
`else
  assign d = bus.digit_in;
  assign bus.err_digit = 1'b0;
`endif
  mul10_add #(.BIN_W(BIN_W)) u_mul10_add (.acc_i(acc_q), .d_i(d), .sum_o(acc_next));
  assign frame_end = bus.digit_last || cnt_q == CNT_W'(NDIG - 1);
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    bin_d   = bin_q;
    if (state_q == HOLD) begin
      if (bus.bin_ready) begin
        state_d = IDLE;
        acc_d   = '0;
        cnt_d   = '0;
      end
    end else if (bus.digit_valid) begin
      acc_d   = acc_next;
      cnt_d   = cnt_q + 1'b1;
      state_d = frame_end ? HOLD : ACCUM;
      bin_d   = frame_end ? acc_next : bin_q;
    end
  end
  always_ff @(posedge clock or negedge reset_b)
    if (!reset_b) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      bin_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      bin_q   <= bin_d;
    end
  assign bus.digit_ready = state_q != HOLD;
  assign bus.bin_valid   = state_q == HOLD;
  assign bus.bin_out     = bin_q;
endmodule

// File: tb/tb_bcd_digits_to_binary.sv
// tb_bcd_digits_to_binary: directed checks of frames, auto-termination, illegal digits, backpressure and reset.
module tb_bcd_digits_to_binary;
  logic clock = 1'b0;
  logic reset_b = 1'b0;
  int errors = 0;
  int checks = 0;
  bcd_digits_to_binary_if #(.BIN_W(14)) bus ();
  bcd_digits_to_binary #(.NDIG(4), .BIN_W(14)) dut (.clock(clock), .reset_b(reset_b), .bus(bus));
  always #5 clock = ~clock;

  task automatic put(input logic [3:0] dg, input logic last);
    bus.digit_in = dg;
    bus.digit_last = last;
    bus.digit_valid = 1'b1;
    @(posedge clock);
    #1;
    bus.digit_valid = 1'b0;
    bus.digit_last = 1'b0;
    bus.digit_in = 4'hx;
  endtask

  task automatic test_reset;
    bus.digit_valid = 1'b0;
    bus.digit_last = 1'b0;
    bus.digit_in = 4'd0;
    bus.bin_ready = 1'b1;
    reset_b = 1'b0;
    #3;
    checks += 4;
    if (bus.bin_out !== 14'd0) begin errors++; $display("FAIL reset bin_out got %0d want 0", bus.bin_out); end
    if (bus.bin_valid !== 1'b0) begin errors++; $display("FAIL reset bin_valid got %b want 0", bus.bin_valid); end
    if (bus.err_digit !== 1'b0) begin errors++; $display("FAIL reset err_digit got %b want 0", bus.err_digit); end
    if (bus.digit_ready !== 1'b1) begin errors++; $display("FAIL reset digit_ready got %b want 1", bus.digit_ready); end
    @(negedge clock);
    reset_b = 1'b1;
    @(posedge clock);
    #1;
  endtask

  task automatic test_basic;
    bus.bin_ready = 1'b1;
    put(4'd1, 1'b0);
    checks++;
    if (bus.bin_valid !== 1'b0) begin errors++; $display("FAIL basic early bin_valid got %b want 0", bus.bin_valid); end
    put(4'd2, 1'b0);
    put(4'd3, 1'b0);
    put(4'd4, 1'b1);
    checks += 4;
    if (bus.bin_valid !== 1'b1) begin errors++; $display("FAIL basic bin_valid got %b want 1", bus.bin_valid); end
    if (bus.bin_out !== 14'd1234) begin errors++; $display("FAIL basic bin_out got %0d want 1234", bus.bin_out); end
    if (bus.err_digit !== 1'b0) begin errors++; $display("FAIL basic err_digit got %b want 0", bus.err_digit); end
    if (bus.digit_ready !== 1'b0) begin errors++; $display("FAIL basic digit_ready got %b want 0", bus.digit_ready); end
    @(posedge clock);
    #1;
    checks += 2;
    if (bus.bin_valid !== 1'b0) begin errors++; $display("FAIL basic one-cycle bin_valid got %b want 0", bus.bin_valid); end
    if (bus.digit_ready !== 1'b1) begin errors++; $display("FAIL basic ready-return got %b want 1", bus.digit_ready); end
  endtask

  task automatic test_single;
    put(4'd7, 1'b1);
    checks += 3;
    if (bus.bin_valid !== 1'b1) begin errors++; $display("FAIL single bin_valid got %b want 1", bus.bin_valid); end
    if (bus.bin_out !== 14'd7) begin errors++; $display("FAIL single bin_out got %0d want 7", bus.bin_out); end
    if (bus.digit_ready !== 1'b0) begin errors++; $display("FAIL single digit_ready got %b want 0", bus.digit_ready); end
    @(posedge clock);
    #1;
    checks++;
    if (bus.digit_ready !== 1'b1) begin errors++; $display("FAIL single ready-return got %b want 1", bus.digit_ready); end
  endtask

  task automatic test_autoterm;
    for (int i = 0; i < 3; i++) put(4'd9, 1'b0);
    checks++;
    if (bus.bin_valid !== 1'b0) begin errors++; $display("FAIL autoterm early bin_valid got %b want 0", bus.bin_valid); end
    put(4'd9, 1'b0);
    checks += 2;
    if (bus.bin_valid !== 1'b1) begin errors++; $display("FAIL autoterm bin_valid got %b want 1", bus.bin_valid); end
    if (bus.bin_out !== 14'd9999) begin errors++; $display("FAIL autoterm bin_out got %0d want 9999", bus.bin_out); end
    @(posedge clock);
    #1;
    put(4'd5, 1'b1);
    checks += 2;
    if (bus.bin_valid !== 1'b1) begin errors++; $display("FAIL autoterm second bin_valid got %b want 1", bus.bin_valid); end
    if (bus.bin_out !== 14'd5) begin errors++; $display("FAIL autoterm second bin_out got %0d want 5", bus.bin_out); end
    @(posedge clock);
    #1;
  endtask

  task automatic test_illegal;
    logic [13:0] exp_bin;
    logic exp_err;
`ifdef BCD2BIN_ERR_EN
    exp_bin = 14'd301;
    exp_err = 1'b1;
`else
    exp_bin = 14'd421;
    exp_err = 1'b0;
`endif
    put(4'd3, 1'b0);
    put(4'hC, 1'b0);
    put(4'd1, 1'b1);
    checks += 3;
    if (bus.bin_valid !== 1'b1) begin errors++; $display("FAIL illegal bin_valid got %b want 1", bus.bin_valid); end
    if (bus.bin_out !== exp_bin) begin errors++; $display("FAIL illegal bin_out got %0d want %0d", bus.bin_out, exp_bin); end
    if (bus.err_digit !== exp_err) begin errors++; $display("FAIL illegal err_digit got %b want %b", bus.err_digit, exp_err); end
    @(posedge clock);
    #1;
    put(4'd6, 1'b1);
    checks += 2;
    if (bus.bin_out !== 14'd6) begin errors++; $display("FAIL illegal next bin_out got %0d want 6", bus.bin_out); end
    if (bus.err_digit !== 1'b0) begin errors++; $display("FAIL illegal err cleared got %b want 0", bus.err_digit); end
    @(posedge clock);
    #1;
  endtask

  task automatic test_backpressure;
    bus.bin_ready = 1'b0;
    put(4'd5, 1'b0);
    put(4'd6, 1'b1);
    bus.digit_in = 4'd9;
    bus.digit_last = 1'b1;
    bus.digit_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      checks += 3;
      if (bus.bin_valid !== 1'b1) begin errors++; $display("FAIL bp[%0d] bin_valid got %b want 1", i, bus.bin_valid); end
      if (bus.bin_out !== 14'd56) begin errors++; $display("FAIL bp[%0d] bin_out got %0d want 56", i, bus.bin_out); end
      if (bus.digit_ready !== 1'b0) begin errors++; $display("FAIL bp[%0d] digit_ready got %b want 0", i, bus.digit_ready); end
      @(posedge clock);
      #1;
    end
    bus.digit_valid = 1'b0;
    bus.digit_last = 1'b0;
    bus.bin_ready = 1'b1;
    @(posedge clock);
    #1;
    checks += 2;
    if (bus.bin_valid !== 1'b0) begin errors++; $display("FAIL bp release bin_valid got %b want 0", bus.bin_valid); end
    if (bus.digit_ready !== 1'b1) begin errors++; $display("FAIL bp release digit_ready got %b want 1", bus.digit_ready); end
    put(4'd2, 1'b0);
    put(4'd3, 1'b1);
    checks++;
    if (bus.bin_out !== 14'd23) begin errors++; $display("FAIL bp next bin_out got %0d want 23", bus.bin_out); end
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset_mid;
    put(4'd4, 1'b0);
    put(4'd2, 1'b0);
    #2;
    reset_b = 1'b0;
    #1;
    checks += 4;
    if (bus.bin_out !== 14'd0) begin errors++; $display("FAIL midreset bin_out got %0d want 0", bus.bin_out); end
    if (bus.bin_valid !== 1'b0) begin errors++; $display("FAIL midreset bin_valid got %b want 0", bus.bin_valid); end
    if (bus.err_digit !== 1'b0) begin errors++; $display("FAIL midreset err_digit got %b want 0", bus.err_digit); end
    if (bus.digit_ready !== 1'b1) begin errors++; $display("FAIL midreset digit_ready got %b want 1", bus.digit_ready); end
    @(negedge clock);
    reset_b = 1'b1;
    @(posedge clock);
    #1;
    put(4'd8, 1'b1);
    checks += 2;
    if (bus.bin_valid !== 1'b1) begin errors++; $display("FAIL midreset next bin_valid got %b want 1", bus.bin_valid); end
    if (bus.bin_out !== 14'd8) begin errors++; $display("FAIL midreset next bin_out got %0d want 8", bus.bin_out); end
    @(posedge clock);
    #1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_single();
    test_autoterm();
    test_illegal();
    test_backpressure();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/bcd_digits_to_binary.md
# bcd_digits_to_binary

- Serial BCD-to-binary accumulator, downstream of the 8,4,−2,−1-to-BCD code converter.
- Accepts one 4-bit BCD digit per handshake, most significant digit first.
- Accumulates the frame as acc·10 + digit and presents the unsigned binary result on a valid/ready output port.
- Flags illegal digit codes (10–15) that the converter emits for unused input codes.

## Interface
- NDIG, 4, maximum digits per frame; the frame auto-terminates at NDIG digits.
- BIN_W, 14, result width; must satisfy 10^NDIG − 1 < 2^BIN_W.
- clock  input  1  rising-edge clock.
- reset_b  input  1  asynchronous, active-low reset.
- digit_in  input  4  BCD digit from the converter.
- digit_valid  input  1  digit_in is valid.
- digit_last  input  1  qualifies the final digit of a frame.
- digit_ready  output  1  block accepts a digit this cycle.
- bin_out  output  BIN_W  accumulated binary result.
- bin_valid  output  1  bin_out and err_digit are valid.
- bin_ready  input  1  consumer accepts the result.
- err_digit  output  1  the frame contained at least one digit > 9.

## Operation
- States:
  - IDLE: no digits yet; acc = 0.
  - ACCUM: at least one digit accepted.
  - HOLD: result presented.
- A digit transfer occurs when digit_valid && digit_ready.
  - On transfer: acc ← acc·10 + d, where d = digit_in if digit_in ≤ 9, else 0 (with ERR_EN).
  - Arithmetic is (acc<<3)+(acc<<1)+d, truncated to BIN_W.
  - The digit counter increments on each transfer.
- Frame end: a transfer with digit_last = 1, or the transfer that brings the count to NDIG.
  - Go to HOLD.
  - bin_out ← new acc; bin_valid ← 1.
- IDLE → ACCUM on a non-final transfer; IDLE → HOLD on a single-digit frame.
- HOLD: digit_ready = 0. bin_out, bin_valid and err_digit stay stable until bin_valid && bin_ready, then return to IDLE.
- Clearing: acc, count and the sticky error clear on leaving HOLD.
- digit_last is ignored except on a transfer. digit_in is don't-care when digit_valid = 0.
- Reset mid-frame discards the partial frame; no result is emitted.

## Timing
- Reset values:
  - state IDLE; acc 0; count 0.
  - bin_out 0; bin_valid 0; err_digit 0.
  - digit_ready 1. It is a combinational decode of state: 1 in IDLE and ACCUM, 0 in HOLD.
- Latency: bin_valid rises on the clock edge that accepts the final digit, i.e. visible 1 cycle after the final transfer cycle.
- No bypass: digit_ready returns high the cycle after the bin handshake. Minimum frame period is N+1 cycles for N digits.
- The result is held indefinitely under bin_ready = 0. bin_ready high on the rising cycle of bin_valid completes the handshake in that cycle.
- No combinational path from digit_valid or bin_ready to any output.

## Configuration
- Macro: BCD2BIN_ERR_EN.
- Defined:
  - digits 10–15 set the sticky error and contribute 0 to acc.
  - err_digit is valid with bin_valid.
- Undefined:
  - no detection logic; err_digit is tied to 0.
  - digits 10–15 are added arithmetically, with the result modulo 2^BIN_W.

## Structure
- Package bcd2bin_pkg holds:
  - the state enum (IDLE, ACCUM, HOLD);
  - constant BCD_MAX = 9;
  - a function computing the minimum BIN_W for a given NDIG, used for an elaboration-time check.
- One sub-module, mul10_add: combinational (acc, d) → acc·10 + d, parameterised by BIN_W.
- Everything else is in the top module: FSM, counter, error flag, output registers.

## Test plan
- Digits 1,2,3,4, last on 4, bin_ready held 1 → bin_out = 1234 (0x4D2), err_digit 0, bin_valid for exactly 1 cycle.
- Single digit 7 with last → bin_out = 7, one cycle after the transfer; digit_ready low for that cycle only.
- NDIG = 4, digits 9,9,9,9 with no last, then 5 with last:
  - first result 9999, auto-terminated;
  - second frame gives 5.
- Digits 3, 0xC, 1, last on 1 with ERR_EN → bin_out = 301, err_digit 1. Without ERR_EN → 3·100 + 12·10 + 1 = 421, err_digit 0.
- Backpressure: result 56, bin_ready low for 10 cycles:
  - bin_out and bin_valid stay stable;
  - digit_ready stays 0;
  - digits offered in this window are not consumed.
- reset_b pulsed low after digits 4,2:
  - all outputs return to reset values asynchronously;
  - next frame 8 with last → bin_out = 8.
